// File: rtl/fcn_drain.sv
// fcn_drain: captures one batch of PE accumulators and drains them lane by lane.
// Each lane gets a bias, rounding right shift, optional ReLU and 9-bit saturation.
// Results are streamed out with valid/ready. A one-cycle pe_clr pulse frees the PEs
// as soon as the batch has been captured.
module fcn_drain #(
  parameter int N_PE  = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_done,
  input  logic [N_PE*24-1:0]   acc_data,
  input  logic [N_PE*16-1:0]   bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic                 pe_clr,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8:0]           out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

  state_t             state_q, state_d;
  logic               capture, advance;
  logic [IDX_W-1:0]   lane_q;
  logic [N_PE*24-1:0] acc_q;
  logic [N_PE*16-1:0] bias_q;
  logic [4:0]         shift_q;
  logic               relu_q;
  logic               pe_clr_q;
  logic               overrun_q;

  logic [23:0]        lane_acc;
  logic [15:0]        lane_bias;
  logic signed [25:0] sum_s;
  logic signed [25:0] rnd_s;
  logic signed [25:0] res_s;
  logic [8:0]         result;

  // Next-state logic: capture a batch from IDLE, advance one lane per accepted beat
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_done) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          advance = 1'b1;
          if (lane_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot of the batch; shift amounts beyond 23 are clamped so the lane math stays bounded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (capture) begin
      acc_q   <= acc_data;
      bias_q  <= bias;
      shift_q <= (shift > 5'd23) ? 5'd23 : shift;
      relu_q  <= relu_en;
    end
  end

  // Lane counter: restarts at each capture and wraps back to 0 after the last lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
    end else if (capture) begin
      lane_q <= '0;
    end else if (advance) begin
      lane_q <= lane_q + IDX_W'(1);
    end
  end

  // One-cycle PE clear pulse in the cycle after a capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_clr_q <= 1'b0;
    end else begin
      pe_clr_q <= capture;
    end
  end

  // Sticky overrun: a new batch completed while the previous one was still draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if ((state_q == SEND) && acc_done) begin
      overrun_q <= 1'b1;
    end
  end

  // Select the current lane's accumulator and bias from the captured snapshot
  always_comb begin
    lane_acc  = '0;
    lane_bias = '0;
    for (int k = 0; k < N_PE; k++) begin
      if (lane_q == IDX_W'(k)) begin
        lane_acc  = acc_q[k*24 +: 24];
        lane_bias = bias_q[k*16 +: 16];
      end
    end
  end

  // Requantize: bias add, round-half-up shift, optional ReLU, saturate to 9 bits
  always_comb begin
    sum_s = $signed({{2{lane_acc[23]}}, lane_acc}) + $signed({{10{lane_bias[15]}}, lane_bias});
    rnd_s = sum_s;
    if (shift_q != 5'd0) begin
      rnd_s = sum_s + $signed(26'd1 << (shift_q - 5'd1));
    end
    res_s = rnd_s >>> shift_q;
    if (relu_q && (res_s < 26'sd0)) begin
      res_s = '0;
    end
    if (res_s > 26'sd255) begin
      result = 9'h0FF;
    end else if (res_s < -26'sd256) begin
      result = 9'h100;
    end else begin
      result = res_s[8:0];
    end
  end

  assign pe_clr    = pe_clr_q;
  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_data  = result;
  assign out_idx   = lane_q;
  assign out_last  = (lane_q == LAST_IDX);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fcn_drain.sv
// tb_fcn_drain: drives batches into fcn_drain and compares every beat against
// a plain-integer model of the requantization rules.
module tb_fcn_drain;

  localparam int N_PE  = 8;
  localparam int IDX_W = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 acc_done;
  logic [N_PE*24-1:0]   acc_data;
  logic [N_PE*16-1:0]   bias;
  logic [4:0]           shift;
  logic                 relu_en;
  logic                 pe_clr;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [8:0]           out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 overrun;

  int passCount  = 0;
  int checkCount = 0;
  int accV[N_PE];
  int biasV[N_PE];
  int expV[N_PE];
  bit expOverrun = 1'b0;

  fcn_drain #(.N_PE(N_PE), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_done  (acc_done),
    .acc_data  (acc_data),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .pe_clr    (pe_clr),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: integer arithmetic straight from the requantization rules
  function automatic int refLane(input int acc, input int b, input int sh, input bit relu);
    longint s;
    int e;
    e = (sh > 23) ? 23 : sh;
    s = longint'(acc) + longint'(b);
    if (e > 0) begin
      s = s + (longint'(1) << (e - 1));
      s = s >>> e;
    end
    if (relu && s < 0) s = 0;
    if (s > 255) s = 255;
    if (s < -256) s = -256;
    return int'(s);
  endfunction

  task automatic fillRandom(input bit big);
    int unsigned r;
    for (int k = 0; k < N_PE; k++) begin
      r = $urandom;
      if (big) accV[k] = int'({{8{r[23]}}, r[23:0]});
      else     accV[k] = int'($urandom_range(0, 4000)) - 2000;
      biasV[k] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = stall pattern 1,0,0,1 around lane 2
  // abortLane: lane at which reset is asserted mid-batch (-1 = none)
  task automatic applyStimulus(input int shiftV, input bit reluV, input int mode,
                               input bit inject, input int abortLane);
    int lane;
    int cycles;
    int stallCnt;
    bit first;
    if (rst_n == 1'b0) rst_n = 1'b1;
    else @(negedge clk);
    for (int k = 0; k < N_PE; k++) begin
      acc_data[k*24 +: 24] = accV[k][23:0];
      bias[k*16 +: 16]     = biasV[k][15:0];
      expV[k] = refLane(accV[k], biasV[k], shiftV, reluV);
    end
    shift    = shiftV[4:0];
    relu_en  = reluV;
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    checkOutput("pe_clr_hi", int'(pe_clr), 1);
    checkOutput("busy_hi", int'(busy), 1);
    lane = 0; cycles = 0; stallCnt = 0; first = 1'b1;
    while (lane < N_PE && cycles < 200) begin
      if (!first) checkOutput("pe_clr_lo", int'(pe_clr), 0);
      first = 1'b0;
      checkOutput("valid", int'(out_valid), 1);
      checkOutput("idx", int'(out_idx), lane);
      checkOutput("data", int'($signed(out_data)), expV[lane]);
      checkOutput("last", int'(out_last), (lane == N_PE - 1) ? 1 : 0);
      checkOutput("overrun", int'(overrun), int'(expOverrun));
      if (lane == abortLane) begin
        acc_done = 1'b0;
        rst_n = 1'b0;
        #1;
        expOverrun = 1'b0;
        checkOutput("rst_pe_clr", int'(pe_clr), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_data", int'(out_data), 0);
        checkOutput("rst_idx", int'(out_idx), 0);
        checkOutput("rst_last", int'(out_last), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (lane == 2) begin
            out_ready = (stallCnt >= 2);
            stallCnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      for (int k = 0; k < N_PE; k++) begin
        acc_data[k*24 +: 24] = 24'($urandom);
        bias[k*16 +: 16]     = 16'($urandom);
      end
      shift   = 5'($urandom);
      relu_en = 1'($urandom);
      if (inject && (($urandom_range(0, 3) == 0) || (out_ready && lane == N_PE - 1))) begin
        acc_done   = 1'b1;
        expOverrun = 1'b1;
      end else begin
        acc_done = 1'b0;
      end
      if (out_ready) lane++;
      cycles++;
      @(negedge clk);
    end
    acc_done = 1'b0;
    checkOutput("bounded", int'(cycles < 200), 1);
    checkOutput("busy_lo", int'(busy), 0);
    checkOutput("valid_lo", int'(out_valid), 0);
    checkOutput("pe_clr_end", int'(pe_clr), 0);
    checkOutput("overrun_end", int'(overrun), int'(expOverrun));
  endtask

  initial begin
    rst_n     = 1'b0;
    acc_done  = 1'b0;
    acc_data  = '0;
    bias      = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init_pe_clr", int'(pe_clr), 0);
    checkOutput("init_busy", int'(busy), 0);
    checkOutput("init_valid", int'(out_valid), 0);
    checkOutput("init_data", int'(out_data), 0);
    checkOutput("init_idx", int'(out_idx), 0);
    checkOutput("init_last", int'(out_last), 0);
    checkOutput("init_overrun", int'(overrun), 0);

    // Ramp -4..3, no bias, no shift, always ready; capture on the edge right after reset release
    for (int k = 0; k < N_PE; k++) begin
      accV[k] = k - 4;
      biasV[k] = 0;
    end
    applyStimulus(0, 1'b0, 0, 1'b0, -1);

    // Rounding examples
    fillRandom(1'b0);
    accV[0] = 1000; biasV[0] = 24;
    applyStimulus(3, 1'b0, 0, 1'b0, -1);
    fillRandom(1'b0);
    accV[0] = -13; biasV[0] = 0;
    applyStimulus(2, 1'b0, 1, 1'b0, -1);

    // Saturation both ways, then ReLU on the negative overflow
    fillRandom(1'b1);
    accV[0] = 100000;  biasV[0] = 0;
    accV[1] = -100000; biasV[1] = 0;
    applyStimulus(4, 1'b0, 0, 1'b0, -1);
    applyStimulus(4, 1'b1, 0, 1'b0, -1);

    // Back-pressure held on lane 2
    fillRandom(1'b0);
    applyStimulus(1, 1'b0, 2, 1'b0, -1);

    // acc_done during the drain, including the final transfer
    fillRandom(1'b0);
    applyStimulus(5, 1'b0, 1, 1'b1, -1);

    // Reset mid-batch at lane 5, then a fresh batch right at reset release
    fillRandom(1'b1);
    applyStimulus(6, 1'b0, 0, 1'b1, 5);
    fillRandom(1'b0);
    applyStimulus(2, 1'b1, 1, 1'b0, -1);

    // Randomized batches, including shift values beyond 23
    for (int b = 0; b < 12; b++) begin
      fillRandom(1'($urandom));
      applyStimulus(int'($urandom_range(0, 31)), 1'($urandom), 1, 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fcn_drain.md
FCN_DRAIN -- requirements
Module: fcn_drain

Interface
REQ-001 Parameter N_PE, default 8: number of PE accumulator lanes drained per batch; power of two, 2..16.
REQ-002 Parameter IDX_W, default 3: lane index width, equal to log2(N_PE).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 acc_done  input  1  PE accumulation complete; acc_data is stable in this cycle.
REQ-006 acc_data  input  N_PE*24  packed signed PE accumulators; lane k occupies bits [24k+23:24k].
REQ-007 bias  input  N_PE*16  packed signed per-lane bias, lane k at bits [16k+15:16k].
REQ-008 shift  input  5  requantization right-shift amount, legal range 0..23.
REQ-009 relu_en  input  1  1 = clamp negative results to 0.
REQ-010 pe_clr  output  1  one-cycle clear pulse to the PE accumulators.
REQ-011 busy  output  1  high while a captured batch is not fully drained.
REQ-012 out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-013 out_ready  input  1  downstream accepts the current output.
REQ-014 out_data  output  9  signed requantized result, in next-layer input format.
REQ-015 out_idx  output  IDX_W  lane number of out_data.
REQ-016 out_last  output  1  high when out_idx = N_PE-1.
REQ-017 overrun  output  1  sticky flag: acc_done arrived while busy.

Function
REQ-018 FSM states: IDLE and SEND only.
REQ-019 IDLE, acc_done=1 at edge T: capture all acc_data, bias, shift (values >23 treated as 23) and relu_en into internal registers; set lane counter to 0; enter SEND.
REQ-020 pe_clr is registered and high exactly in cycle T+1 after each capture; low otherwise.
REQ-021 out_valid and busy go high in cycle T+1 (latency 1) and present lane 0.
REQ-022 SEND: a transfer occurs on a rising edge where out_valid and out_ready are both 1; the lane counter then increments.
REQ-023 Transfer with out_last=1: return to IDLE; out_valid and busy low in the next cycle.
REQ-024 While out_valid=1 and out_ready=0: out_data, out_idx and out_last are held stable.
REQ-025 acc_done in SEND, including the cycle of the final transfer: ignored and not captured; overrun set to 1; captured data unaffected.
REQ-026 Arithmetic step 1: s = sign-extend(acc) + sign-extend(bias), computed in 25 bits with no overflow.
REQ-027 Arithmetic step 2: if shift > 0, add 2^(shift-1) to s (round half up), then arithmetic right shift by shift; if shift = 0, pass s unchanged.
REQ-028 Arithmetic step 3: if relu_en=1 and the result is negative, force 0.
REQ-029 Arithmetic step 4: saturate to the signed 9-bit range [-256, 255].
REQ-030 out_data is a pure function of the captured registers and the lane counter, never of live inputs.
REQ-031 overrun is cleared only by reset.

Reset
REQ-032 On rst_n low: state IDLE, lane counter 0, and pe_clr, busy, out_valid, out_data, out_idx, out_last, overrun all 0; all capture registers cleared to 0.
REQ-033 Reset asserted mid-SEND aborts the batch; there is no pe_clr pulse after reset release.
REQ-034 The first acc_done is honoured on the first rising edge at which rst_n is high.

Verification
REQ-035 N_PE=8, shift=0, bias=0, relu_en=0, lane k acc = k-4, out_ready=1: pe_clr high for 1 cycle; 8 consecutive beats -4..3; out_last on beat 8; busy low one cycle after beat 8.
REQ-036 acc=1000, bias=24, shift=3: 1024+4 = 1028, >>3 = 128. acc=-13, bias=0, shift=2: -13+2 = -11, >>2 = -3.
REQ-037 acc=100000, shift=4 -> out_data 255; acc=-100000, relu_en=0 -> -256; same negative value with relu_en=1 -> 0.
REQ-038 Toggle out_ready 1,0,0,1 during lane 2: out_idx stays 2 and out_data stays stable across the stall; no beat is lost or duplicated.
REQ-039 acc_done pulsed during SEND with different acc_data: remaining beats show the original data; overrun=1 and stays 1 until reset.
REQ-040 rst_n low while out_idx=5: all outputs 0 on assertion; after release, a new acc_done produces lane 0 of the new data.
